// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

endpackage

// File: rtl/loader_word_assembler.sv
// Packs accepted bytes little-endian into a 32-bit word and keeps a running XOR checksum.
module loader_word_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              accept,
  input  logic [7:0]        data,
  output logic [WORD_W-1:0] word,
  output logic              word_full,
  output logic [7:0]        chk
);

  localparam int CNT_BITS = $clog2(BYTES_PER_WORD);

  logic [CNT_BITS-1:0] byte_cnt;

  // byte_cnt wraps to 0 after the last byte, so the next word starts cleanly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt <= '0;
      word     <= '0;
      chk      <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      word     <= '0;
      chk      <= '0;
    end else if (accept) begin
      word[{byte_cnt, 3'b000} +: 8] <= data;
      chk                           <= chk ^ data;
      byte_cnt                      <= byte_cnt + CNT_BITS'(1);
    end
  end

  assign word_full = accept && (byte_cnt == CNT_BITS'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams bytes into instruction memory words, verifies an XOR checksum, gates core reset.
// Handshake: a byte transfers on a rising edge only when byte_valid && byte_ready; otherwise nothing changes.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          WORDS      = 256,
  parameter int          CNT_W      = 9,
  parameter logic [31:0] START_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_words,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [31:0]       imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              core_rst,
  output logic [2:0]        dbg_state
);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  n_q;
  logic [CNT_W-1:0]  word_idx;
  logic [CNT_W-1:0]  n_sat;
  logic [31:0]       addr_q;
  logic              load;
  logic              asm_accept;
  logic              asm_full;
  logic [7:0]        asm_chk;
  logic              word_last;

  assign n_sat      = (num_words > CNT_W'(WORDS)) ? CNT_W'(WORDS) : num_words;
  assign load       = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
  assign asm_accept = byte_valid && (state == ST_RECV);
  assign word_last  = (word_idx + CNT_W'(1)) == n_q;

  loader_word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (load),
    .accept    (asm_accept),
    .data      (byte_data),
    .word      (imem_wdata),
    .word_full (asm_full),
    .chk       (asm_chk)
  );

  // word_idx and the address only advance when another word follows, so they stay within n-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      n_q      <= '0;
      word_idx <= '0;
      addr_q   <= START_ADDR;
    end else begin
      state <= state_nxt;
      if (load) begin
        n_q      <= n_sat;
        word_idx <= '0;
        addr_q   <= START_ADDR;
      end else if (state == ST_WRITE && !word_last) begin
        word_idx <= word_idx + CNT_W'(1);
        addr_q   <= addr_q + 32'd4;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    imem_we    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    core_rst   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) state_nxt = (n_sat == '0) ? ST_CHECK : ST_RECV;
      end
      ST_RECV: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (asm_full) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        imem_we   = 1'b1;
        busy      = 1'b1;
        state_nxt = word_last ? ST_CHECK : ST_RECV;
      end
      ST_CHECK: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) state_nxt = (byte_data == asm_chk) ? ST_DONE : ST_ERR;
      end
      ST_DONE: begin
        done     = 1'b1;
        core_rst = 1'b1;
        if (start) state_nxt = (n_sat == '0) ? ST_CHECK : ST_RECV;
      end
      ST_ERR: begin
        error = 1'b1;
        if (start) state_nxt = (n_sat == '0) ? ST_CHECK : ST_RECV;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign imem_addr = addr_q;
  assign dbg_state = state;

endmodule
